// File: rtl/qoi_pkg.sv
// rtl/qoi_pkg.sv - shared types, opcodes and hash for the QOI encoder
package qoi_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_EMIT,
        ST_END
    } state_t;

    localparam logic [7:0] OP_INDEX = 8'h00;
    localparam logic [7:0] OP_DIFF  = 8'h40;
    localparam logic [7:0] OP_LUMA  = 8'h80;
    localparam logic [7:0] OP_RUN   = 8'hC0;
    localparam logic [7:0] OP_RGB   = 8'hFE;

    localparam logic [7:0] END_MARK_LAST = 8'h01;
    localparam int         END_LEN       = 8;

    // Alpha is fixed at 255, so its 255*11 term folds into a constant.
    function automatic logic [5:0] qoi_hash(input pixel_t p);
        logic [13:0] s;
        s = 14'(p.r) * 14'd3 + 14'(p.g) * 14'd5 + 14'(p.b) * 14'd7 + 14'd2805;
        return s[5:0];
    endfunction

endpackage

// File: rtl/qoi_encoder_core_if.sv
// rtl/qoi_encoder_core_if.sv - pixel input stream and encoded byte output stream
interface qoi_encoder_core_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_last;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_last;

    modport master (
        output pix_valid, pix_data, pix_last, byte_ready,
        input  pix_ready, byte_valid, byte_data, byte_last
    );

    modport slave (
        input  pix_valid, pix_data, pix_last, byte_ready,
        output pix_ready, byte_valid, byte_data, byte_last
    );
endinterface

// File: rtl/qoi_index_table.sv
// rtl/qoi_index_table.sv - 64-entry colour index with valid bits and clear-all
module qoi_index_table
    import qoi_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    input  logic [IDX_BITS-1:0] rd_addr,
    output pixel_t              rd_data,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_addr,
    input  pixel_t              wr_data
);
    localparam int N = 1 << IDX_BITS;

    pixel_t         ent [N];
    logic [N-1:0]   vld;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            vld <= '0;
        end else if (wr_en) begin
            vld[wr_addr] <= 1'b1;
        end
    end

    // Entry contents need no reset; the valid bits gate every lookup.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = ent[rd_addr];
    assign rd_valid = vld[rd_addr];

endmodule

// File: rtl/qoi_encoder_core.sv
// rtl/qoi_encoder_core.sv - streaming QOI chunk encoder with end marker
module qoi_encoder_core
    import qoi_pkg::*;
#(
    parameter int MAX_RUN  = 62,
    parameter int IDX_BITS = 6
) (
    input  logic              clk,
    input  logic              reset,
    qoi_encoder_core_if.slave s,
    output logic              busy
);
    state_t        state;
    pixel_t        prev;
    logic [5:0]    run;
    logic [39:0]   obuf;
    logic [2:0]    ocnt;
    logic          last_q;
    logic [2:0]    ecnt;

    pixel_t              px;
    logic [IDX_BITS-1:0] h;
    pixel_t              idx_data;
    logic                idx_valid;
    logic                idx_wr;
    logic                idx_clear;

    logic [39:0]   nseq;
    logic [2:0]    nbytes;
    logic [5:0]    run_nx;
    pixel_t        prev_nx;
    logic [6:0]    run_inc;
    logic [7:0]    dr, dg, db, lg, lr, lb;
    logic          is_diff, is_luma;

    assign px      = s.pix_data;
    assign h       = IDX_BITS'(qoi_hash(px));
    assign run_inc = {1'b0, run} + 7'd1;

    assign dr = px.r - prev.r;
    assign dg = px.g - prev.g;
    assign db = px.b - prev.b;
    // Biasing each signed delta turns the range tests into unsigned compares.
    assign is_diff = (8'(dr + 8'd2) < 8'd4) && (8'(dg + 8'd2) < 8'd4) && (8'(db + 8'd2) < 8'd4);
    assign lg = dg + 8'd32;
    assign lr = dr - dg + 8'd8;
    assign lb = db - dg + 8'd8;
    assign is_luma = (lg < 8'd64) && (lr < 8'd16) && (lb < 8'd16);

    always_comb begin
        nseq    = '0;
        nbytes  = 3'd0;
        run_nx  = run;
        prev_nx = prev;
        idx_wr  = 1'b0;
        if (px == prev) begin
            if (run_inc == 7'(MAX_RUN) || s.pix_last) begin
                nseq[39:32] = OP_RUN | {2'b00, run};
                nbytes      = 3'd1;
                run_nx      = 6'd0;
            end else begin
                run_nx = run_inc[5:0];
            end
        end else begin
            if (run != 6'd0) begin
                nseq[39:32] = OP_RUN | {2'b00, run - 6'd1};
                nbytes      = 3'd1;
            end
            run_nx  = 6'd0;
            prev_nx = px;
            if (idx_valid && idx_data == px) begin
                nseq   = nseq | ({OP_INDEX | 8'(h), 32'd0} >> {nbytes, 3'b000});
                nbytes = nbytes + 3'd1;
            end else begin
                idx_wr = 1'b1;
                if (is_diff) begin
                    nseq   = nseq | ({OP_DIFF | {2'b00, dr[1:0] + 2'd2, dg[1:0] + 2'd2, db[1:0] + 2'd2}, 32'd0}
                                     >> {nbytes, 3'b000});
                    nbytes = nbytes + 3'd1;
                end else if (is_luma) begin
                    nseq   = nseq | ({OP_LUMA | {2'b00, lg[5:0]}, lr[3:0], lb[3:0], 24'd0} >> {nbytes, 3'b000});
                    nbytes = nbytes + 3'd2;
                end else begin
                    nseq   = nseq | ({OP_RGB, px, 8'd0} >> {nbytes, 3'b000});
                    nbytes = nbytes + 3'd4;
                end
            end
        end
    end

    assign idx_clear = (state == ST_END) && s.byte_ready && (ecnt == 3'(END_LEN - 1));

    qoi_index_table #(.IDX_BITS(IDX_BITS)) u_index (
        .clk      (clk),
        .resetn   (reset),
        .clear    (idx_clear),
        .rd_addr  (h),
        .rd_data  (idx_data),
        .rd_valid (idx_valid),
        .wr_en    (idx_wr && state == ST_ACCEPT && s.pix_valid),
        .wr_addr  (h),
        .wr_data  (px)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_ACCEPT;
            prev   <= '0;
            run    <= 6'd0;
            obuf   <= '0;
            ocnt   <= 3'd0;
            last_q <= 1'b0;
            ecnt   <= 3'd0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_ACCEPT: begin
                    if (s.pix_valid) begin
                        busy <= 1'b1;
                        prev <= prev_nx;
                        run  <= run_nx;
                        if (nbytes != 3'd0) begin
                            obuf   <= nseq;
                            ocnt   <= nbytes;
                            last_q <= s.pix_last;
                            state  <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    if (s.byte_ready) begin
                        obuf <= {obuf[31:0], 8'd0};
                        ocnt <= ocnt - 3'd1;
                        ecnt <= 3'd0;
                        if (ocnt == 3'd1) begin
                            state <= last_q ? ST_END : ST_ACCEPT;
                        end
                    end
                end
                ST_END: begin
                    if (s.byte_ready) begin
                        if (ecnt == 3'(END_LEN - 1)) begin
                            state <= ST_ACCEPT;
                            busy  <= 1'b0;
                            prev  <= '0;
                            run   <= 6'd0;
                        end else begin
                            ecnt <= ecnt + 3'd1;
                        end
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

    assign s.pix_ready  = (state == ST_ACCEPT);
    assign s.byte_valid = (state != ST_ACCEPT);
    assign s.byte_last  = (state == ST_END) && (ecnt == 3'(END_LEN - 1));
    assign s.byte_data  = (state == ST_END) ? ((ecnt == 3'(END_LEN - 1)) ? END_MARK_LAST : 8'h00)
                                            : obuf[39:32];

endmodule
